// File: rtl/ps2_keyboard_fifo.sv
// ps2_keyboard_fifo
// Memory-mapped PS/2 keyboard receiver. Decodes PS/2 frames (start, 8 data
// bits LSB first, odd parity, stop) into scan codes. The codes are buffered
// in a DEPTH-entry FIFO so the CPU can poll at any rate.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   data       raw PS/2 data pin (asynchronous)
//   DataAdr    bus address, only [3:2] decoded
//   WriteData  bus write data
//   enable     block select from the address decoder
//   MemWrite   1 = write, 0 = read
//   ReadData   combinational read data, 0 when not selected
//   irq        registered interrupt request
//
// Register map (DataAdr[3:2])
//   0 DATA    RO  {23'b0, nonempty, head}; a read pops the head when nonempty
//   1 STATUS      {16'b0, count, 3'b0, frame_err, parity_err, overflow, full, empty}
//                 writing 1 to bits [4:2] clears the matching sticky flag
//   2 CONTROL RW  bit0 rx_en (reset 1), bit1 irq_en (reset 0)
//   3             reads 0, writes ignored
module ps2_keyboard_fifo #(
  parameter int DEPTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        data,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        enable,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} st_t;

  // ---------------- input synchronisers and clock filter ----------------
  // Both synchronisers reset to the idle-high bus level.
  logic [1:0]    csync, dsync;
  logic          ck_s, d_s;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          accept, fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csync <= 2'b11;
      dsync <= 2'b11;
    end else begin
      csync <= {csync[0], ps2_clk};
      dsync <= {dsync[0], data};
    end
  end

  assign ck_s = csync[1];
  assign d_s  = dsync[1];

  // fcnt counts consecutive synchronised samples that differ from the
  // accepted level; the FILTER_LEN-th such sample flips the level, and a
  // 1->0 flip is reported as a falling edge in that same cycle.
  assign accept = (ck_s != filt) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall   = accept && !ck_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (ck_s == filt) begin
      fcnt <= '0;
    end else if (accept) begin
      filt <= ck_s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // ---------------- receive FSM ----------------
  st_t           state, nstate;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          parbit;
  logic [TW-1:0] tocnt;
  logic          timeout;
  logic          push, set_perr, set_ferr;
  logic          rx_en, irq_en;

  assign timeout = (state != S_IDLE) && !fall && (tocnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (!rx_en || timeout) begin
      nstate = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:  if (!d_s) nstate = S_DATA;
        S_DATA:  if (bitcnt == 3'd7) nstate = S_PAR;
        S_PAR:   nstate = S_STOP;
        default: nstate = S_IDLE;
      endcase
    end
  end

  // Stop-bit outcome: a bad stop bit outranks a parity error. Disabling
  // the receiver aborts silently.
  always_comb begin
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    if (rx_en) begin
      if (timeout) begin
        set_ferr = 1'b1;
      end else if (fall && state == S_STOP) begin
        if (!d_s)                     set_ferr = 1'b1;
        else if (!(^{shreg, parbit})) set_perr = 1'b1;
        else                          push     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt <= '0;
      shreg  <= '0;
      parbit <= 1'b0;
      tocnt  <= '0;
    end else begin
      if (fall && rx_en) begin
        case (state)
          S_IDLE: bitcnt <= '0;
          S_DATA: begin
            shreg  <= {d_s, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          S_PAR:  parbit <= d_s;
          default: ;
        endcase
      end
      if (state == S_IDLE || fall) tocnt <= '0;
      else if (!timeout)           tocnt <= tocnt + 1'b1;
    end
  end

  // ---------------- bus decode and FIFO ----------------
  logic [1:0]    sel;
  logic          rd, wr;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_ok, set_ovf;
  logic          ovf, perr, ferr;
  logic [2:0]    clr;
  logic [7:0]    cnt8;
  logic          unused_ok;

  assign sel   = DataAdr[3:2];
  assign rd    = enable && !MemWrite;
  assign wr    = enable && MemWrite;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd && (sel == 2'd0) && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);
  assign set_ovf = push && full && !pop;
  assign clr     = (wr && sel == 2'd1) ? WriteData[4:2] : 3'b000;
  assign cnt8    = 8'(count);
  assign unused_ok = ^{DataAdr[31:4], DataAdr[1:0], WriteData[31:5]};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= shreg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf    <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      rx_en  <= 1'b1;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ovf  <= set_ovf  || (ovf  && !clr[0]);
      perr <= set_perr || (perr && !clr[1]);
      ferr <= set_ferr || (ferr && !clr[2]);
      if (wr && sel == 2'd2) begin
        rx_en  <= WriteData[0];
        irq_en <= WriteData[1];
      end
      irq <= irq_en && (!empty || ovf || perr || ferr);
    end
  end

  always_comb begin
    ReadData = '0;
    if (enable) begin
      case (sel)
        2'd0:    ReadData = {23'b0, !empty, empty ? 8'h00 : mem[rp]};
        2'd1:    ReadData = {16'b0, cnt8, 3'b0, ferr, perr, ovf, full, empty};
        2'd2:    ReadData = {30'b0, irq_en, rx_en};
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: doc/ps2_keyboard_fifo.md
# ps2_keyboard_fifo

Memory-mapped PS/2 keyboard receiver with a parametrised scan-code FIFO, error flags and an interrupt line. It is the next-generation replacement for the separate keyboard driver/keyboard register pair. It sits on the ARM data bus behind the addressing decoder and is selected by its own enable. It decodes PS/2 frames and buffers DEPTH codes so the CPU can poll at any rate.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- FILTER_LEN, 4: consecutive equal samples required before a synchronised ps2_clk level is accepted.
- TIMEOUT, 50000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- data  in  1  raw PS/2 data pin (asynchronous).
- DataAdr  in  32  bus address; only [3:2] decoded.
- WriteData  in  32  bus write data.
- enable  in  1  block select from addressing decoder.
- MemWrite  in  1  1 = write, 0 = read.
- ReadData  out  32  combinational read data; 0 when enable=0.
- irq  out  1  registered interrupt request.

## Operation
- Registers, selected by DataAdr[3:2]:
  - 0 DATA (RO): returns {23'b0, nonempty, head[7:0]}. A read pops the head on the clock edge when the FIFO is nonempty. Reading while empty returns 0 and has no effect.
  - 1 STATUS: {16'b0, count[7:0], 3'b0, frame_err, parity_err, overflow, full, empty}. Writing 1 to bits [4:2] clears the corresponding sticky flag.
  - 2 CONTROL (RW): bit0 rx_en (reset 1), bit1 irq_en (reset 0). Other bits read 0.
  - 3: reads 0, writes ignored.
- Input path: 2-flop synchroniser on both pins. ps2_clk passes through a FILTER_LEN glitch filter. A falling edge of the filtered clock samples synchronised data.
- Receive FSM (LSB first, odd parity):
  - IDLE: edge with data=0 → DATA, bit counter=0. Edge with data=1 is ignored.
  - DATA: shift in 8 bits, then → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: →IDLE.
    - data=1 and parity good → push the byte.
    - parity bad → set parity_err, drop the byte.
    - stop=0 → set frame_err, drop the byte. This takes precedence over a parity error.
  - Any non-IDLE state: TIMEOUT cycles without an edge → IDLE, set frame_err, drop the partial byte.
  - rx_en=0: FSM is held in IDLE and edges are ignored. Clearing rx_en mid-frame aborts the frame with no flag set.
- FIFO: circular, log2(DEPTH)-bit pointers that wrap modulo DEPTH. count ranges 0..DEPTH.
  - Push when full: drop the new byte, set overflow. Existing contents are unchanged.
  - Simultaneous push and pop: both happen and count is unchanged. When full, the pop frees a slot, so the push is accepted with no overflow.
  - Pop and push in the same cycle while empty: no pop; the push succeeds.
- irq next-state = irq_en & (nonempty | overflow | parity_err | frame_err).

## Timing
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; pointers, count, flags and irq go to 0.
  - rx_en=1, irq_en=0; filters settle to the idle-high level.
  - ReadData then reads STATUS = 0x00000001.
- Pin-to-edge latency: 2 sync cycles + FILTER_LEN cycles.
- Push takes effect the cycle after the stop-bit edge is detected. STATUS/DATA reflect it from that cycle on. irq rises one cycle later.
- Pop: ReadData shows the head combinationally in the read cycle. The head advances at the end of that cycle, so back-to-back reads return successive bytes.
- Flag clear and a simultaneous set in the same cycle: set wins.
- Reset asserted mid-frame aborts the frame with no flag set. The FIFO is emptied.

## Test plan
- Send a valid frame for 0x1C (parity 0) → STATUS count=1, empty=0. DATA read returns 0x0000011C, then STATUS=0x00000001.
- Send 0x1C with parity bit 1 → nothing pushed, STATUS=0x00000009. Writing 0x8 to STATUS clears it to 0x00000001.
- Send DEPTH+1 valid codes 0x01..0x09 with DEPTH=8 → count=8, full=1, overflow=1. Reads return 0x01..0x08 in order; 0x09 is lost.
- Stop a frame after 4 data bits and idle TIMEOUT cycles → frame_err=1, FSM in IDLE. The next valid 0x5A frame is received correctly.
- irq_en=1, FIFO full: a pop and a stop-bit push land in the same cycle → count stays 8, no overflow, the new byte is at the tail, irq stays 1.
- Pulse reset low mid-frame with 3 bytes buffered → ReadData at STATUS = 0x00000001 and irq=0 immediately.
